// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared state encodings, opcode/funct constants and ALU codes
package cpu_defs;

  typedef enum logic [4:0] {
    S_RESET       = 5'd0,
    S_FETCH       = 5'd1,
    S_FETCH_WAIT  = 5'd2,
    S_IR_LOAD     = 5'd3,
    S_DECODE      = 5'd4,
    S_EXEC_R      = 5'd5,
    S_WB_R        = 5'd6,
    S_EXEC_I      = 5'd7,
    S_WB_I        = 5'd8,
    S_ADDR        = 5'd9,
    S_MEM_RD      = 5'd10,
    S_MEM_RD_WAIT = 5'd11,
    S_WB_LW       = 5'd12,
    S_MEM_WR      = 5'd13,
    S_BRANCH      = 5'd14,
    S_JUMP        = 5'd15,
    S_HALT        = 5'd16
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_BREAK = 6'h0D;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;

  localparam logic [2:0] ULA_PASS = 3'b000;
  localparam logic [2:0] ULA_ADD  = 3'b001;
  localparam logic [2:0] ULA_SUB  = 3'b010;
  localparam logic [2:0] ULA_AND  = 3'b011;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_ADDI   = 3'd1,
    CLS_MEM    = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_JUMP   = 3'd4,
    CLS_HALT   = 3'd5
  } instr_class_e;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       ab_write;
    logic       aluout_write;
    logic       sel_ula_a;
    logic [1:0] sel_ula_b;
    logic [2:0] ula_func;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - classifies opcode/funct into an instruction class and R-type ALU op
module ctrl_decode
  import cpu_defs::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] instr_class,
  output logic [2:0] r_ula_func,
  output logic       r_checks_ovflw
);

  always_comb begin
    instr_class    = CLS_HALT;
    r_ula_func     = ULA_ADD;
    r_checks_ovflw = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin
            instr_class    = CLS_R;
            r_checks_ovflw = 1'b1;
          end
          FN_SUB: begin
            instr_class    = CLS_R;
            r_ula_func     = ULA_SUB;
            r_checks_ovflw = 1'b1;
          end
          // and cannot overflow, so it always writes back
          FN_AND: begin
            instr_class = CLS_R;
            r_ula_func  = ULA_AND;
          end
          FN_BREAK: instr_class = CLS_HALT;
          default:  instr_class = CLS_HALT;
        endcase
      end
      OP_ADDI:       instr_class = CLS_ADDI;
      OP_LW, OP_SW:  instr_class = CLS_MEM;
      OP_BEQ, OP_BNE: instr_class = CLS_BRANCH;
      OP_J:          instr_class = CLS_JUMP;
      default:       instr_class = CLS_HALT;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle Moore control FSM with registered datapath controls
module control_unit
  import cpu_defs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       ula_zero,
  input  logic       ula_ovflw,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       ab_write,
  output logic       aluout_write,
  output logic       sel_ula_A,
  output logic [1:0] sel_ula_B,
  output logic [2:0] ula_func,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       halted,
  output logic [4:0] state
);

  state_e     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [2:0] instr_class;
  logic [2:0] r_ula_func;
  logic       r_checks_ovflw;
  logic       branch_taken;

  ctrl_decode u_decode (
    .opcode         (opcode),
    .funct          (funct),
    .instr_class    (instr_class),
    .r_ula_func     (r_ula_func),
    .r_checks_ovflw (r_checks_ovflw)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET:       state_d = S_FETCH;
      S_FETCH:       state_d = S_FETCH_WAIT;
      S_FETCH_WAIT:  state_d = S_IR_LOAD;
      S_IR_LOAD:     state_d = S_DECODE;
      S_DECODE: begin
        case (instr_class)
          CLS_R:      state_d = S_EXEC_R;
          CLS_ADDI:   state_d = S_EXEC_I;
          CLS_MEM:    state_d = S_ADDR;
          CLS_BRANCH: state_d = S_BRANCH;
          CLS_JUMP:   state_d = S_JUMP;
          default:    state_d = S_HALT;
        endcase
      end
      S_EXEC_R:      state_d = (ula_ovflw && r_checks_ovflw) ? S_FETCH : S_WB_R;
      S_EXEC_I:      state_d = ula_ovflw ? S_FETCH : S_WB_I;
      S_ADDR:        state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:      state_d = S_MEM_RD_WAIT;
      S_MEM_RD_WAIT: state_d = S_WB_LW;
      S_WB_R, S_WB_I, S_WB_LW, S_MEM_WR, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_HALT:        state_d = S_HALT;
      default:       state_d = S_RESET;
    endcase
  end

  // Controls are precomputed for the state being entered so they leave a flop
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_FETCH, S_FETCH_WAIT: begin
        ctrl_d.sel_ula_a = 1'b1;
        ctrl_d.sel_ula_b = 2'b01;
        ctrl_d.ula_func  = ULA_ADD;
      end
      S_IR_LOAD: begin
        ctrl_d.ir_write  = 1'b1;
        ctrl_d.pc_write  = 1'b1;
        ctrl_d.pc_source = 2'b00;
        ctrl_d.sel_ula_a = 1'b1;
        ctrl_d.sel_ula_b = 2'b01;
        ctrl_d.ula_func  = ULA_ADD;
      end
      S_DECODE: begin
        ctrl_d.ab_write     = 1'b1;
        ctrl_d.aluout_write = 1'b1;
        ctrl_d.sel_ula_a    = 1'b1;
        ctrl_d.sel_ula_b    = 2'b11;
        ctrl_d.ula_func     = ULA_ADD;
      end
      S_EXEC_R: begin
        ctrl_d.sel_ula_b    = 2'b00;
        ctrl_d.ula_func     = r_ula_func;
        ctrl_d.aluout_write = 1'b1;
      end
      S_EXEC_I, S_ADDR: begin
        ctrl_d.sel_ula_b    = 2'b10;
        ctrl_d.ula_func     = ULA_ADD;
        ctrl_d.aluout_write = 1'b1;
      end
      S_WB_R: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.reg_dst   = 1'b1;
      end
      S_WB_I:                  ctrl_d.reg_write = 1'b1;
      S_MEM_RD, S_MEM_RD_WAIT: ctrl_d.iord = 1'b1;
      S_WB_LW: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_d.iord      = 1'b1;
        ctrl_d.mem_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl_d.sel_ula_b = 2'b00;
        ctrl_d.ula_func  = ULA_SUB;
        ctrl_d.pc_source = 2'b01;
      end
      S_JUMP: begin
        ctrl_d.pc_write  = 1'b1;
        ctrl_d.pc_source = 2'b10;
      end
      S_HALT:  ctrl_d.halted = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // The zero flag is only valid while BRANCH itself runs the compare
  assign branch_taken = ((opcode == OP_BEQ) && ula_zero) || ((opcode == OP_BNE) && !ula_zero);

  assign pc_write     = ctrl_q.pc_write | ((state_q == S_BRANCH) && branch_taken);
  assign pc_source    = ctrl_q.pc_source;
  assign iord         = ctrl_q.iord;
  assign mem_write    = ctrl_q.mem_write;
  assign ir_write     = ctrl_q.ir_write;
  assign ab_write     = ctrl_q.ab_write;
  assign aluout_write = ctrl_q.aluout_write;
  assign sel_ula_A    = ctrl_q.sel_ula_a;
  assign sel_ula_B    = ctrl_q.sel_ula_b;
  assign ula_func     = ctrl_q.ula_func;
  assign reg_write    = ctrl_q.reg_write;
  assign reg_dst      = ctrl_q.reg_dst;
  assign mem_to_reg   = ctrl_q.mem_to_reg;
  assign halted       = ctrl_q.halted;
  assign state        = state_q;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit
module tb_control_unit;
  import cpu_defs::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       ula_zero, ula_ovflw;
  logic       pc_write, iord, mem_write, ir_write, ab_write, aluout_write;
  logic       sel_ula_A, reg_write, reg_dst, mem_to_reg, halted;
  logic [1:0] pc_source, sel_ula_B;
  logic [2:0] ula_func;
  logic [4:0] state;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .ula_zero(ula_zero), .ula_ovflw(ula_ovflw),
    .pc_write(pc_write), .pc_source(pc_source), .iord(iord), .mem_write(mem_write),
    .ir_write(ir_write), .ab_write(ab_write), .aluout_write(aluout_write),
    .sel_ula_A(sel_ula_A), .sel_ula_B(sel_ula_B), .ula_func(ula_func),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .halted(halted), .state(state)
  );

  wire [17:0] all_outs = {pc_write, pc_source, iord, mem_write, ir_write, ab_write,
                          aluout_write, sel_ula_A, sel_ula_B, ula_func, reg_write,
                          reg_dst, mem_to_reg, halted};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instruction-level reference: latency and per-instruction strobe budget
  task automatic model(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic ov, output int lat, output int pcw, output int regw,
                       output int memw, output int iordc, output bit halt, output int ula,
                       output int dst, output int m2r, output int pcsrc);
    lat = 5; pcw = 1; regw = 0; memw = 0; iordc = 0; halt = 0;
    ula = -1; dst = -1; m2r = -1; pcsrc = 0;
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
      ula = (fn == 6'h20) ? 1 : (fn == 6'h22) ? 2 : 3;
      if (!(ov && fn != 6'h24)) begin lat = 6; regw = 1; dst = 1; m2r = 0; end
    end else if (op == 6'h08) begin
      ula = 1;
      if (!ov) begin lat = 6; regw = 1; dst = 0; m2r = 0; end
    end else if (op == 6'h23) begin
      lat = 8; regw = 1; dst = 0; m2r = 1; iordc = 2; ula = 1;
    end else if (op == 6'h2B) begin
      lat = 6; memw = 1; iordc = 1; ula = 1;
    end else if (op == 6'h04 || op == 6'h05) begin
      ula = 2;
      if ((op == 6'h04) == z) begin pcw = 2; pcsrc = 1; end
    end else if (op == 6'h02) begin
      ula = 0; pcw = 2; pcsrc = 2;
    end else begin
      halt = 1; lat = 4;
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input logic ov);
    int lat, pcw, regw, memw, iordc, ula, dst, m2r, pcsrc;
    bit halt;
    int cyc, o_pcw, o_irw, o_abw, o_regw, o_memw, o_iord, o_ula, o_dst, o_m2r, o_pcsrc, bad;
    if (state !== S_FETCH) begin
      reset = 1'b1; step(); reset = 1'b0; step();
    end
    model(op, fn, z, ov, lat, pcw, regw, memw, iordc, halt, ula, dst, m2r, pcsrc);
    opcode = op; funct = fn; ula_zero = z; ula_ovflw = ov;
    cyc = 0; o_pcw = 0; o_irw = 0; o_abw = 0; o_regw = 0; o_memw = 0; o_iord = 0;
    o_ula = -1; o_dst = -1; o_m2r = -1; o_pcsrc = 0;
    do begin
      if (pc_write) begin o_pcw++; if (cyc > 2) o_pcsrc = pc_source; end
      if (ir_write) o_irw++;
      if (ab_write) o_abw++;
      if (reg_write) begin o_regw++; o_dst = reg_dst; o_m2r = mem_to_reg; end
      if (mem_write) o_memw++;
      if (iord) o_iord++;
      if (cyc == 4) o_ula = ula_func;
      step();
      cyc++;
    end while (state !== S_FETCH && !halted && cyc < 20);

    vectors++; if (cyc != lat) begin errors++; $display("FAIL latency op=%h fn=%h: got %0d want %0d", op, fn, cyc, lat); end
    vectors++; if (halted !== halt) begin errors++; $display("FAIL halted op=%h fn=%h: got %b want %b", op, fn, halted, halt); end
    vectors++; if (o_pcw != pcw) begin errors++; $display("FAIL pc_write_count op=%h z=%b: got %0d want %0d", op, z, o_pcw, pcw); end
    vectors++; if (o_irw != 1) begin errors++; $display("FAIL ir_write_count op=%h: got %0d want 1", op, o_irw); end
    vectors++; if (o_abw != 1) begin errors++; $display("FAIL ab_write_count op=%h: got %0d want 1", op, o_abw); end
    vectors++; if (o_regw != regw) begin errors++; $display("FAIL reg_write_count op=%h fn=%h ov=%b: got %0d want %0d", op, fn, ov, o_regw, regw); end
    vectors++; if (o_memw != memw) begin errors++; $display("FAIL mem_write_count op=%h: got %0d want %0d", op, o_memw, memw); end
    vectors++; if (o_iord != iordc) begin errors++; $display("FAIL iord_count op=%h: got %0d want %0d", op, o_iord, iordc); end
    vectors++; if (o_ula != ula) begin errors++; $display("FAIL ula_func op=%h fn=%h: got %0d want %0d", op, fn, o_ula, ula); end
    vectors++; if (o_dst != dst || o_m2r != m2r) begin errors++; $display("FAIL wb_select op=%h: got dst=%0d m2r=%0d want dst=%0d m2r=%0d", op, o_dst, o_m2r, dst, m2r); end
    vectors++; if (o_pcsrc != pcsrc) begin errors++; $display("FAIL pc_source op=%h z=%b: got %0d want %0d", op, z, o_pcsrc, pcsrc); end

    if (halt && halted) begin
      bad = 0;
      repeat (20) begin
        step();
        if (!halted || pc_write || ir_write || reg_write || mem_write || ab_write || aluout_write) bad++;
      end
      vectors++; if (bad != 0) begin errors++; $display("FAIL halt_hold op=%h: got %0d bad cycles want 0", op, bad); end
      reset = 1'b1; step();
      vectors++; if (state !== 5'd0 || all_outs !== '0) begin errors++; $display("FAIL halt_reset: got state=%0d outs=%h want 0/0", state, all_outs); end
      reset = 1'b0; step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; opcode = 6'h00; funct = 6'h20; ula_zero = 1'b0; ula_ovflw = 1'b0;
    repeat (2) step();
    vectors++; if (state !== 5'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    vectors++; if (all_outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", all_outs); end
    reset = 1'b0; step();
    vectors++; if (state !== S_FETCH) begin errors++; $display("FAIL reset_release: got %0d want %0d", state, S_FETCH); end
    vectors++; if (sel_ula_A !== 1'b1 || sel_ula_B !== 2'b01 || ula_func !== 3'b001) begin
      errors++; $display("FAIL fetch_outputs: got A=%b B=%b f=%b want 1/01/001", sel_ula_A, sel_ula_B, ula_func);
    end
  endtask

  task automatic test_r_sequence();
    logic [4:0] exp_seq [8];
    logic [4:0] got;
    exp_seq[0] = 5'd0;     exp_seq[1] = S_FETCH;  exp_seq[2] = S_FETCH_WAIT; exp_seq[3] = S_IR_LOAD;
    exp_seq[4] = S_DECODE; exp_seq[5] = S_EXEC_R; exp_seq[6] = S_WB_R;       exp_seq[7] = S_FETCH;
    opcode = 6'h00; funct = 6'h20; ula_ovflw = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      got = state;
      vectors++; if (got !== exp_seq[i]) begin errors++; $display("FAIL r_seq[%0d]: got %0d want %0d", i, got, exp_seq[i]); end
      if (i == 5) begin
        vectors++; if (ula_func !== 3'b001) begin errors++; $display("FAIL r_seq_func: got %b want 001", ula_func); end
      end
      if (i == 6) begin
        vectors++; if (reg_write !== 1'b1 || reg_dst !== 1'b1) begin errors++; $display("FAIL r_seq_wb: got rw=%b rd=%b want 1/1", reg_write, reg_dst); end
      end
      if (i < 7) step();
    end
  endtask

  task automatic test_alu_ops();
    run_instr(6'h00, 6'h20, 1'b0, 1'b0);
    run_instr(6'h00, 6'h22, 1'b1, 1'b0);
    run_instr(6'h00, 6'h24, 1'b0, 1'b1);
    run_instr(6'h08, 6'h11, 1'b0, 1'b0);
  endtask

  task automatic test_load_store();
    run_instr(6'h23, 6'h00, 1'b0, 1'b0);
    run_instr(6'h2B, 6'h00, 1'b0, 1'b0);
  endtask

  task automatic test_branch_jump();
    run_instr(6'h04, 6'h00, 1'b1, 1'b0);
    run_instr(6'h05, 6'h00, 1'b1, 1'b0);
    run_instr(6'h04, 6'h00, 1'b0, 1'b0);
    run_instr(6'h05, 6'h00, 1'b0, 1'b0);
    run_instr(6'h02, 6'h00, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    run_instr(6'h08, 6'h00, 1'b0, 1'b1);
    run_instr(6'h00, 6'h20, 1'b0, 1'b1);
    run_instr(6'h00, 6'h22, 1'b0, 1'b1);
  endtask

  task automatic test_halt();
    run_instr(6'h3F, 6'h00, 1'b0, 1'b0);
    run_instr(6'h00, 6'h0D, 1'b0, 1'b0);
  endtask

  task automatic test_reset_in_mem_wr();
    int cyc;
    run_instr(6'h02, 6'h00, 1'b0, 1'b0);
    opcode = 6'h2B; funct = 6'h00; ula_zero = 1'b0; ula_ovflw = 1'b0;
    cyc = 0;
    while (state !== S_MEM_WR && cyc < 12) begin step(); cyc++; end
    vectors++; if (mem_write !== 1'b1) begin errors++; $display("FAIL mid_wr_strobe: got %b want 1", mem_write); end
    reset = 1'b1; step();
    vectors++; if (mem_write !== 1'b0 || state !== 5'd0) begin
      errors++; $display("FAIL mid_wr_abort: got mw=%b state=%0d want 0/0", mem_write, state);
    end
    reset = 1'b0; step();
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [10];
    logic [5:0] fns [5];
    logic [5:0] op, fn;
    ops[0] = 6'h00; ops[1] = 6'h00; ops[2] = 6'h08; ops[3] = 6'h23; ops[4] = 6'h2B;
    ops[5] = 6'h04; ops[6] = 6'h05; ops[7] = 6'h02; ops[8] = 6'h00; ops[9] = 6'h00;
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h0D; fns[4] = 6'h00;
    for (int n = 0; n < 80; n++) begin
      op = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 11) == 0) op = 6'($urandom_range(0, 63));
      fn = fns[$urandom_range(0, 4)];
      if (fn == 6'h00) fn = 6'($urandom_range(0, 63));
      run_instr(op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_r_sequence();
    test_alu_ops();
    test_load_store();
    test_branch_jump();
    test_overflow();
    test_halt();
    test_reset_in_mem_wr();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
